// File: rtl/shared_mem_arbiter_pkg.sv
// Shared definitions for the gpu shared-memory arbiter: sizing, FSM state
// encoding and the opcodes latched for the granted access.
package shared_mem_arbiter_pkg;

  localparam int NUM_CORES = 16;
  localparam int ADDR_W    = 12;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_LD = 4'd11,
    OP_ST = 4'd13
  } op_t;

endpackage

// File: rtl/shared_mem_arbiter_sm_ram.sv
// Single-port 2^ADDR_W x 8 RAM with synchronous read and write.
// A same-address write returns the old byte (read-before-write).
module sm_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  // Array storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter giving NUM_CORES gpu cores one access at a time to a
// shared byte RAM. Each access is IDLE -> ACCESS -> RESP, three cycles.
//
// Handshake: a core holds mem_req_ld/mem_req_st (level) until it samples its
// val_data bit high; val_data is a one-cycle pulse and mem_dat is valid only
// in that cycle. Requests are sampled only in IDLE, so the IDLE cycle that
// follows RESP keeps a request dropped on the val_data edge from re-granting.
module shared_mem_arbiter #(
  parameter int NUM_CORES = shared_mem_arbiter_pkg::NUM_CORES,
  parameter int ADDR_W    = shared_mem_arbiter_pkg::ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req_ld,
  input  logic [NUM_CORES-1:0]        mem_req_st,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_flat,
  input  logic [NUM_CORES*8-1:0]      dat_st_flat,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [7:0]                  mem_dat,
  output logic                        busy,
  output logic [3:0]                  grant_id,
  output shared_mem_arbiter_pkg::state_t state_dbg
);
  import shared_mem_arbiter_pkg::*;

  localparam int CW = IDX_W + 1;

  state_t               state, state_next;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     winner;
  logic [NUM_CORES-1:0] pending;
  logic                 grant_en;
  logic                 found;
  logic [CW-1:0]        cand;
  logic [ADDR_W-1:0]    addr_q;
  logic [7:0]           data_q;
  op_t                  op_q;
  logic                 ram_en;
  logic                 ram_we;

  assign pending  = mem_req_ld | mem_req_st;
  assign grant_en = (state == IDLE) && (|pending);

  // Search starts one past the previous winner and wraps modulo NUM_CORES.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = {1'b0, last_grant} + CW'(i);
      if (cand >= CW'(NUM_CORES)) begin
        cand = cand - CW'(NUM_CORES);
      end
      if (!found && pending[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = grant_en ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_CORES - 1);
      grant_id   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_LD;
    end else begin
      state <= state_next;
      if (grant_en) begin
        last_grant <= winner;
        grant_id   <= winner;
        addr_q     <= addr_flat[int'(winner)*ADDR_W +: ADDR_W];
        data_q     <= dat_st_flat[int'(winner)*8 +: 8];
        // A store wins over a simultaneous load; the read still happens.
        op_q       <= mem_req_st[winner] ? OP_ST : OP_LD;
      end
    end
  end

  // Every access reads, so a store returns the byte it overwrote.
  assign ram_en = (state == ACCESS);
  assign ram_we = ram_en && (op_q == OP_ST);

  sm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (mem_dat)
  );

  always_comb begin
    val_data = '0;
    if (state == RESP) begin
      val_data[grant_id] = 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 16, the number of requesting gpu cores.
REQ-002 The block SHALL have parameter ADDR_W, default 12, the shared memory address width (4096 bytes).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port mem_req_ld, input, NUM_CORES bits: per-core load request level.
REQ-006 The block SHALL have the port mem_req_st, input, NUM_CORES bits: per-core store request level.
REQ-007 The block SHALL have the port addr_flat, input, NUM_CORES*ADDR_W bits: core k's address in slice [k*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have the port dat_st_flat, input, NUM_CORES*8 bits: core k's store data in slice [k*8 +: 8].
REQ-009 The block SHALL have the port val_data, output, NUM_CORES bits: one-hot, one-cycle completion pulse to the served core.
REQ-010 The block SHALL have the port mem_dat, output, 8 bits: load data broadcast to all cores, valid while val_data is non-zero.
REQ-011 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have the port grant_id, output, 4 bits: index of the core currently served (debug).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ACCESS and RESP; any unused encoding SHALL return to IDLE.
REQ-014 In IDLE, core k is pending when mem_req_ld[k] | mem_req_st[k]; with any core pending, the block SHALL latch the winner, its address, its data and its op, and go to ACCESS.
REQ-015 Arbitration SHALL be round-robin: the search starts at last_grant+1 and wraps modulo NUM_CORES; last_grant updates to the winner.
REQ-016 In ACCESS, at the closing edge, the block SHALL perform one RAM write for a store or one synchronous RAM read for a load, then go to RESP.
REQ-017 In RESP, val_data[grant_id] SHALL be 1 for exactly one cycle, with mem_dat equal to the read byte; the FSM SHALL then return to IDLE.
REQ-018 Latency from a request sampled in IDLE to val_data SHALL be exactly 2 cycles; throughput SHALL be one access per 3 cycles.
REQ-019 Hold-off: the core drops its request on the edge that samples val_data, so the mandatory IDLE cycle after RESP SHALL prevent re-granting a stale request.
REQ-020 Simultaneous ld and st from one core: the store SHALL win, and mem_dat SHALL return the pre-write byte (read-before-write); a single val_data pulse SHALL answer both.
REQ-021 Requests from non-granted cores SHALL be held by the cores and never dropped; no core SHALL wait more than NUM_CORES grants.
REQ-022 The address SHALL be used unmodified, with no wrap or range check; store data SHALL be 8 bits unmodified.
REQ-023 Outside RESP, val_data SHALL be 0 and mem_dat SHALL hold its last value.
REQ-024 Request changes during ACCESS or RESP SHALL be ignored; only the latched copies are used.

Reset
REQ-025 While reset=0, the block SHALL force state=IDLE, val_data=0, mem_dat=0, busy=0, grant_id=0 and last_grant=NUM_CORES-1, so that core 0 wins first.
REQ-026 Reset asserted during ACCESS SHALL suppress the pending RAM write; RAM contents SHALL not be cleared by reset.
REQ-027 Reset asserted during RESP SHALL cancel the val_data pulse immediately (asynchronously).

Structure
REQ-028 NUM_CORES, ADDR_W, the state encoding and the opcode values LD=11 and ST=13 SHALL live in the shared gpu package.
REQ-029 The memory SHALL be the sub-module sm_ram: 2^ADDR_W x 8, one port, synchronous read and write, with read-before-write on a same-address write.

Verification
REQ-030 Test single store: core 3 writes addr 0x1A5 data 0x5C -> val_data=0x0008 two cycles later; a following core 3 load of 0x1A5 returns mem_dat=0x5C.
REQ-031 Test round-robin order: cores 0, 5 and 15 request simultaneously after reset -> grants in order 0, 5, 15 at 3-cycle spacing.
REQ-032 Test wrap-around: last_grant=14 and cores 2 and 15 pending -> core 15 is served before core 2.
REQ-033 Test ld+st together: core 7 asserts both at addr 0x010 holding 0x11 with data 0x22 -> mem_dat=0x11, one pulse, and a later load returns 0x22.
REQ-034 Test hold-off: core 4 issues back-to-back loads (request re-raised the cycle after val_data) -> exactly one val_data per request, with no duplicate grant.
REQ-035 Test reset in ACCESS during a store of 0xFF to 0x0C3 -> no val_data, and address 0x0C3 keeps its prior value.
